// File: rtl/spi_master_sched.sv
// spi_master_sched: round-robin arbiter sharing one mode-0 SPI master (MSB first, SCLK idles low).
// Define SPI_ABORT_EN to add the abort input and aborted output.
module spi_master_sched #(
    parameter int NREQ    = 2,
    parameter int DATA_W  = 8,
    parameter int LEN_W   = 4,
    parameter int CLK_DIV = 4
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*LEN_W-1:0]  req_len,
    input  logic [NREQ*DATA_W-1:0] tx_data,
    output logic [NREQ-1:0]        grant,
    output logic                   busy,
    output logic                   tx_load,
    output logic [DATA_W-1:0]      rx_data,
    output logic                   rx_valid,
    output logic                   done,
    output logic                   cs_n,
    output logic                   sclk,
    output logic                   mosi,
    input  logic                   miso
`ifdef SPI_ABORT_EN
    ,
    input  logic                   abort,
    output logic                   aborted
`endif
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_MAX = BW'(DATA_W - 1);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP} state_t;

    state_t              state_q;
    logic [IW-1:0]       own_q;
    logic [IW-1:0]       ptr_q;
    logic [CW-1:0]       cnt_q;
    logic [BW-1:0]       bit_q;
    logic [LEN_W-1:0]    word_q;
    logic [DATA_W-2:0]   tx_sr_q;
    logic [DATA_W-2:0]   rx_sr_q;
    logic [NREQ-1:0]     grant_q;
    logic                busy_q;
    logic                tx_load_q;
    logic [DATA_W-1:0]   rx_data_q;
    logic                rx_valid_q;
    logic                done_q;
    logic                cs_n_q;
    logic                sclk_q;
    logic                mosi_q;

    logic                win_any_d;
    logic [IW-1:0]       win_idx_d;
    logic [DATA_W-1:0]   win_tx_d;
    logic [LEN_W-1:0]    win_len_d;
    logic [DATA_W-1:0]   own_tx_d;
    logic [DATA_W-1:0]   rx_word_d;
    logic                abort_hit;
    int                  arb_j;

    // Search starts just after the last owner so every requester gets its turn.
    always_comb begin
        win_any_d = 1'b0;
        win_idx_d = '0;
        arb_j     = 0;
        for (int k = 1; k <= NREQ; k++) begin
            arb_j = int'(ptr_q) + k;
            if (arb_j >= NREQ) arb_j = arb_j - NREQ;
            if (!win_any_d && req[IW'(arb_j)]) begin
                win_any_d = 1'b1;
                win_idx_d = IW'(arb_j);
            end
        end
    end

    assign win_tx_d  = tx_data[win_idx_d*DATA_W +: DATA_W];
    assign win_len_d = req_len[win_idx_d*LEN_W +: LEN_W];
    assign own_tx_d  = tx_data[own_q*DATA_W +: DATA_W];
    assign rx_word_d = {rx_sr_q, miso};

`ifdef SPI_ABORT_EN
    logic abort_pend_q;
    logic aborted_q;
    logic in_run;

    assign in_run    = (state_q == S_SETUP) || (state_q == S_SHIFT);
    assign abort_hit = in_run && (abort_pend_q || abort);
    assign aborted   = aborted_q;

    // The request is remembered until GAP entry so it can be reported alongside done.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            abort_pend_q <= 1'b0;
            aborted_q    <= 1'b0;
        end else begin
            abort_pend_q <= in_run ? (abort_pend_q || abort)
                                   : ((state_q == S_HOLD) && abort_pend_q);
            aborted_q    <= (state_q == S_HOLD) && (cnt_q == CNT_MAX) && abort_pend_q;
        end
    end
`else
    assign abort_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            own_q      <= '0;
            ptr_q      <= IW'(NREQ - 1);
            cnt_q      <= '0;
            bit_q      <= '0;
            word_q     <= '0;
            tx_sr_q    <= '0;
            rx_sr_q    <= '0;
            grant_q    <= '0;
            busy_q     <= 1'b0;
            tx_load_q  <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            done_q     <= 1'b0;
            cs_n_q     <= 1'b1;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
        end else begin
            tx_load_q  <= 1'b0;
            rx_valid_q <= 1'b0;
            done_q     <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (win_any_d) begin
                        state_q   <= S_SETUP;
                        own_q     <= win_idx_d;
                        grant_q   <= NREQ'(1) << win_idx_d;
                        busy_q    <= 1'b1;
                        cs_n_q    <= 1'b0;
                        tx_load_q <= 1'b1;
                        tx_sr_q   <= win_tx_d[DATA_W-2:0];
                        mosi_q    <= win_tx_d[DATA_W-1];
                        word_q    <= (win_len_d == '0) ? LEN_W'(1) : win_len_d;
                        bit_q     <= '0;
                        cnt_q     <= '0;
                    end
                end
                // SETUP ends with the first rising edge; SHIFT then toggles at every boundary.
                S_SETUP, S_SHIFT: begin
                    if (cnt_q != CNT_MAX) begin
                        cnt_q <= cnt_q + CW'(1);
                    end else begin
                        cnt_q <= '0;
                        if (abort_hit) begin
                            sclk_q  <= 1'b0;
                            state_q <= S_HOLD;
                        end else if (!sclk_q) begin
                            if (word_q == '0) begin
                                state_q <= S_HOLD;
                            end else begin
                                state_q <= S_SHIFT;
                                sclk_q  <= 1'b1;
                                rx_sr_q <= rx_word_d[DATA_W-2:0];
                                if (bit_q == BIT_MAX) begin
                                    rx_data_q  <= rx_word_d;
                                    rx_valid_q <= 1'b1;
                                end
                            end
                        end else begin
                            sclk_q <= 1'b0;
                            if (bit_q != BIT_MAX) begin
                                bit_q   <= bit_q + BW'(1);
                                mosi_q  <= tx_sr_q[DATA_W-2];
                                tx_sr_q <= tx_sr_q << 1;
                            end else begin
                                // Word boundary: word_q reaching 0 marks the final low half-period.
                                bit_q  <= '0;
                                word_q <= word_q - LEN_W'(1);
                                if (word_q != LEN_W'(1)) begin
                                    tx_load_q <= 1'b1;
                                    tx_sr_q   <= own_tx_d[DATA_W-2:0];
                                    mosi_q    <= own_tx_d[DATA_W-1];
                                end else begin
                                    tx_sr_q <= '0;
                                    mosi_q  <= 1'b0;
                                end
                            end
                        end
                    end
                end
                S_HOLD: begin
                    if (cnt_q != CNT_MAX) begin
                        cnt_q <= cnt_q + CW'(1);
                    end else begin
                        cnt_q   <= '0;
                        state_q <= S_GAP;
                        cs_n_q  <= 1'b1;
                        done_q  <= 1'b1;
                        grant_q <= '0;
                        ptr_q   <= own_q;
                    end
                end
                S_GAP: begin
                    if (cnt_q != CNT_MAX) begin
                        cnt_q <= cnt_q + CW'(1);
                    end else begin
                        cnt_q   <= '0;
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign grant    = grant_q;
    assign busy     = busy_q;
    assign tx_load  = tx_load_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign done     = done_q;
    assign cs_n     = cs_n_q;
    assign sclk     = sclk_q;
    assign mosi     = mosi_q;

endmodule
